// File: rtl/nvdla_csb_initiator_if.sv
// Boundary bundle of the CSB initiator: host command/completion side,
// CSB request/response side and the stray-response counter.
interface nvdla_csb_initiator_if;
   // host command
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic        cmd_nposted;
   logic [21:0] cmd_addr;
   logic [31:0] cmd_wdat;
   logic [3:0]  cmd_wrbe;
   // CSB request
   logic        csb_req_pvld;
   logic        csb_req_prdy;
   logic [62:0] csb_req_pd;
   // CSB response
   logic        csb_resp_valid;
   logic [33:0] csb_resp_pd;
   // host completion
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdat;
   logic        rsp_error;
   logic        rsp_timeout;
   // diagnostics
   logic [7:0]  stray_cnt;

   // initiator view
   modport master (
      input  cmd_valid, cmd_write, cmd_nposted, cmd_addr, cmd_wdat, cmd_wrbe,
      output cmd_ready,
      output csb_req_pvld, csb_req_pd,
      input  csb_req_prdy,
      input  csb_resp_valid, csb_resp_pd,
      output rsp_valid, rsp_rdat, rsp_error, rsp_timeout,
      input  rsp_ready,
      output stray_cnt
   );

   // host / CSB target view
   modport slave (
      output cmd_valid, cmd_write, cmd_nposted, cmd_addr, cmd_wdat, cmd_wrbe,
      input  cmd_ready,
      input  csb_req_pvld, csb_req_pd,
      output csb_req_prdy,
      output csb_resp_valid, csb_resp_pd,
      input  rsp_valid, rsp_rdat, rsp_error, rsp_timeout,
      output rsp_ready,
      input  stray_cnt
   );
endinterface

// File: rtl/nvdla_csb_initiator.sv
// Single-outstanding CSB initiator: accepts one host command, issues it as a
// CSB request packet, waits for the matching response (or times out) and
// presents one completion to the host. Responses arriving when nothing is
// pending are dropped and counted.
module nvdla_csb_initiator #(
   parameter int TIMEOUT = 255
) (
   input  logic                    nvdla_core_clk,
   input  logic                    nvdla_core_rst,
   nvdla_csb_initiator_if.master   csb_if
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // last WAIT cycle index before a timeout completion is declared
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [62:0] r_req_pd;
   logic [15:0] r_cnt;
   logic [31:0] r_rdat;
   logic        r_error;
   logic        r_timeout;
   logic [7:0]  r_stray;

   logic        w_cmd_hs;
   logic        w_req_hs;
   logic        w_resp_hit;
   logic        w_timeout;
   logic        w_stray;
   logic        w_posted;
   logic        w_pend_write;

   // Request packet layout: level[62:61]=0, wrbe[60:57], srcpriv[56]=0,
   // nposted[55], write[54], wdat[53:22], addr[21:0]. Write-only fields are
   // forced to zero for reads so the target never sees stale data.
   function automatic logic [62:0] pack_req(
      input logic        write,
      input logic        nposted,
      input logic [21:0] addr,
      input logic [31:0] wdat,
      input logic [3:0]  wrbe
   );
      logic [31:0] v_wdat;
      logic [3:0]  v_wrbe;
      logic        v_np;
      v_wdat = write ? wdat    : 32'd0;
      v_wrbe = write ? wrbe    : 4'd0;
      v_np   = write ? nposted : 1'b0;
      return {2'b00, v_wrbe, 1'b0, v_np, write, v_wdat, addr};
   endfunction

   // A response is in error if the target flagged it, or if its type bit
   // (write ack vs read data) disagrees with what is pending.
   function automatic logic resp_err(
      input logic [33:0] pd,
      input logic        pend_write
   );
      return pd[32] | (pd[33] != pend_write);
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign w_pend_write = r_req_pd[54];
   assign w_posted     = r_req_pd[54] & ~r_req_pd[55];
   assign w_cmd_hs     = (r_state == S_IDLE) & csb_if.cmd_valid;
   assign w_req_hs     = (r_state == S_REQ) & csb_if.csb_req_prdy;
   assign w_resp_hit   = (r_state == S_WAIT) & csb_if.csb_resp_valid;
   assign w_timeout    = (r_state == S_WAIT) & ~csb_if.csb_resp_valid & (r_cnt == CNT_LAST);
   assign w_stray      = (r_state != S_WAIT) & csb_if.csb_resp_valid;

   // Next-state selection; a response beats a coincident timeout.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (csb_if.cmd_valid) w_state_nxt = S_REQ;
         S_REQ:  if (csb_if.csb_req_prdy) w_state_nxt = w_posted ? S_DONE : S_WAIT;
         S_WAIT: if (csb_if.csb_resp_valid || (r_cnt == CNT_LAST)) w_state_nxt = S_DONE;
         S_DONE: if (csb_if.rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) r_state <= S_IDLE;
      else                r_state <= w_state_nxt;
   end

   // Request packet captured at command acceptance, held through REQ/WAIT.
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) r_req_pd <= '0;
      else if (w_cmd_hs)
         r_req_pd <= pack_req(csb_if.cmd_write, csb_if.cmd_nposted, csb_if.cmd_addr,
                              csb_if.cmd_wdat, csb_if.cmd_wrbe);
   end

   // WAIT cycle counter: cleared on request issue, counts idle WAIT cycles.
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst)                      r_cnt <= '0;
      else if (w_req_hs)                       r_cnt <= '0;
      else if ((r_state == S_WAIT) && !csb_if.csb_resp_valid && !w_timeout)
                                               r_cnt <= r_cnt + 16'd1;
   end

   // Completion fields, loaded on the transition into DONE and then held.
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         r_rdat    <= '0;
         r_error   <= 1'b0;
         r_timeout <= 1'b0;
      end else if (w_req_hs && w_posted) begin
         r_rdat    <= '0;
         r_error   <= 1'b0;
         r_timeout <= 1'b0;
      end else if (w_resp_hit) begin
         r_rdat    <= csb_if.csb_resp_pd[31:0];
         r_error   <= resp_err(csb_if.csb_resp_pd, w_pend_write);
         r_timeout <= 1'b0;
      end else if (w_timeout) begin
         r_rdat    <= '0;
         r_error   <= 1'b1;
         r_timeout <= 1'b1;
      end
   end

   // Saturating count of responses that arrive with nothing pending.
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) r_stray <= '0;
      else if (w_stray)   r_stray <= sat_inc8(r_stray);
   end

   assign csb_if.cmd_ready    = (r_state == S_IDLE);
   assign csb_if.csb_req_pvld = (r_state == S_REQ);
   assign csb_if.csb_req_pd   = r_req_pd;
   assign csb_if.rsp_valid    = (r_state == S_DONE);
   assign csb_if.rsp_rdat     = r_rdat;
   assign csb_if.rsp_error    = r_error;
   assign csb_if.rsp_timeout  = r_timeout;
   assign csb_if.stray_cnt    = r_stray;

endmodule

// File: tb/tb_nvdla_csb_initiator.sv
// Directed bench for the CSB initiator, built with TIMEOUT=4 so the timeout
// paths are short.
module tb_nvdla_csb_initiator;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;

   nvdla_csb_initiator_if bus();

   nvdla_csb_initiator #(.TIMEOUT(4)) dut (
      .nvdla_core_clk (clk),
      .nvdla_core_rst (rst),
      .csb_if         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // present a command for one cycle, then check the issued request
   task automatic send_cmd(input string tag, input logic wr, input logic np,
                           input logic [21:0] addr, input logic [31:0] wdat,
                           input logic [3:0] be, input logic [62:0] exp_pd);
      chk({tag, ".cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
      bus.cmd_valid   = 1'b1;
      bus.cmd_write   = wr;
      bus.cmd_nposted = np;
      bus.cmd_addr    = addr;
      bus.cmd_wdat    = wdat;
      bus.cmd_wrbe    = be;
      step();
      bus.cmd_valid   = 1'b0;
      chk({tag, ".pvld"}, 64'(bus.csb_req_pvld), 64'd1);
      chk({tag, ".pd"}, 64'(bus.csb_req_pd), 64'(exp_pd));
      chk({tag, ".busy"}, 64'(bus.cmd_ready), 64'd0);
   endtask

   task automatic accept_req();
      bus.csb_req_prdy = 1'b1;
      step();
      bus.csb_req_prdy = 1'b0;
   endtask

   task automatic respond(input logic [33:0] pd);
      bus.csb_resp_valid = 1'b1;
      bus.csb_resp_pd    = pd;
      step();
      bus.csb_resp_valid = 1'b0;
   endtask

   task automatic check_rsp(input string tag, input logic [31:0] rdat,
                            input logic err, input logic to);
      chk({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
      chk({tag, ".rdat"}, 64'(bus.rsp_rdat), 64'(rdat));
      chk({tag, ".error"}, 64'(bus.rsp_error), 64'(err));
      chk({tag, ".timeout"}, 64'(bus.rsp_timeout), 64'(to));
   endtask

   task automatic finish_rsp(input string tag);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      chk({tag, ".rsp_gone"}, 64'(bus.rsp_valid), 64'd0);
      chk({tag, ".idle"}, 64'(bus.cmd_ready), 64'd1);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst = 1'b1;
      bus.cmd_valid = 1'b0;  bus.cmd_write = 1'b0; bus.cmd_nposted = 1'b0;
      bus.cmd_addr  = '0;    bus.cmd_wdat  = '0;   bus.cmd_wrbe    = '0;
      bus.csb_req_prdy = 1'b0;
      bus.csb_resp_valid = 1'b0; bus.csb_resp_pd = '0;
      bus.rsp_ready = 1'b0;
      step(); step();

      // reset values
      chk("rst.pvld", 64'(bus.csb_req_pvld), 64'd0);
      chk("rst.pd", 64'(bus.csb_req_pd), 64'd0);
      chk("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst.rdat", 64'(bus.rsp_rdat), 64'd0);
      chk("rst.error", 64'(bus.rsp_error), 64'd0);
      chk("rst.timeout", 64'(bus.rsp_timeout), 64'd0);
      chk("rst.stray", 64'(bus.stray_cnt), 64'd0);
      rst = 1'b0;
      step();
      chk("rst.cmd_ready", 64'(bus.cmd_ready), 64'd1);

      // read: write-only fields must be masked out of the packet
      send_cmd("rd1", 1'b0, 1'b1, 22'h000010, 32'hFFFFFFFF, 4'hF, 63'h10);
      accept_req();
      chk("rd1.wait_pvld", 64'(bus.csb_req_pvld), 64'd0);
      chk("rd1.wait_nrsp", 64'(bus.rsp_valid), 64'd0);
      respond({1'b0, 1'b0, 32'hDEADBEEF});
      check_rsp("rd1", 32'hDEADBEEF, 1'b0, 1'b0);
      chk("rd1.stray", 64'(bus.stray_cnt), 64'd0);
      finish_rsp("rd1");

      // posted write with target backpressure for 3 cycles
      send_cmd("pw", 1'b1, 1'b0, 22'h3FFFFF, 32'h12345678, 4'hF, 63'h1E448D159E3FFFFF);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("pw.hold_pvld", 64'(bus.csb_req_pvld), 64'd1);
         chk("pw.hold_pd", 64'(bus.csb_req_pd), 64'h1E448D159E3FFFFF);
      end
      accept_req();
      check_rsp("pw", 32'h0, 1'b0, 1'b0);
      finish_rsp("pw");

      // non-posted write, response of wrong type
      send_cmd("np1", 1'b1, 1'b1, 22'h000100, 32'hA5A5A5A5, 4'h3,
               {2'b00, 4'h3, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 22'h000100});
      accept_req();
      respond({1'b0, 1'b0, 32'h11111111});
      check_rsp("np1", 32'h11111111, 1'b1, 1'b0);
      finish_rsp("np1");

      // non-posted write, target error flag
      send_cmd("np2", 1'b1, 1'b1, 22'h000104, 32'h00000001, 4'h1,
               {2'b00, 4'h1, 1'b0, 1'b1, 1'b1, 32'h00000001, 22'h000104});
      accept_req();
      respond({1'b1, 1'b1, 32'h0});
      check_rsp("np2", 32'h0, 1'b1, 1'b0);
      finish_rsp("np2");

      // non-posted write, clean ack
      send_cmd("np3", 1'b1, 1'b1, 22'h000108, 32'h00000002, 4'hC,
               {2'b00, 4'hC, 1'b0, 1'b1, 1'b1, 32'h00000002, 22'h000108});
      accept_req();
      respond({1'b1, 1'b0, 32'h0});
      check_rsp("np3", 32'h0, 1'b0, 1'b0);
      finish_rsp("np3");

      // read answered with a write-type response
      send_cmd("rdty", 1'b0, 1'b0, 22'h000014, 32'h0, 4'h0, 63'h14);
      accept_req();
      respond({1'b1, 1'b0, 32'h55AA55AA});
      check_rsp("rdty", 32'h55AA55AA, 1'b1, 1'b0);
      finish_rsp("rdty");

      // read with no response: timeout after 4 WAIT cycles
      send_cmd("to", 1'b0, 1'b0, 22'h000020, 32'h0, 4'h0, 63'h20);
      accept_req();
      for (int i = 0; i < 4; i++) begin
         chk("to.pending", 64'(bus.rsp_valid), 64'd0);
         step();
      end
      check_rsp("to", 32'h0, 1'b1, 1'b1);
      finish_rsp("to");
      respond({1'b0, 1'b0, 32'h12121212});
      chk("to.late_stray", 64'(bus.stray_cnt), 64'd1);
      chk("to.late_idle", 64'(bus.rsp_valid), 64'd0);

      // stray counter saturation
      bus.csb_resp_valid = 1'b1;
      for (int i = 0; i < 253; i++) step();
      chk("stray.254", 64'(bus.stray_cnt), 64'd254);
      for (int i = 0; i < 47; i++) step();
      bus.csb_resp_valid = 1'b0;
      chk("stray.sat", 64'(bus.stray_cnt), 64'd255);

      // response in the timeout cycle wins; completion held under backpressure
      send_cmd("co", 1'b0, 1'b0, 22'h000030, 32'h0, 4'h0, 63'h30);
      accept_req();
      for (int i = 0; i < 3; i++) step();
      chk("co.pending", 64'(bus.rsp_valid), 64'd0);
      respond({1'b0, 1'b0, 32'hCAFEF00D});
      for (int i = 0; i < 5; i++) begin
         check_rsp("co.hold", 32'hCAFEF00D, 1'b0, 1'b0);
         chk("co.busy", 64'(bus.cmd_ready), 64'd0);
         step();
      end
      check_rsp("co", 32'hCAFEF00D, 1'b0, 1'b0);
      finish_rsp("co");

      // reset while waiting abandons the transaction
      send_cmd("rw", 1'b0, 1'b0, 22'h000040, 32'h0, 4'h0, 63'h40);
      accept_req();
      step();
      rst = 1'b1;
      #1;
      chk("rw.pvld", 64'(bus.csb_req_pvld), 64'd0);
      chk("rw.pd", 64'(bus.csb_req_pd), 64'd0);
      chk("rw.rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rw.rdat", 64'(bus.rsp_rdat), 64'd0);
      chk("rw.error", 64'(bus.rsp_error), 64'd0);
      chk("rw.timeout", 64'(bus.rsp_timeout), 64'd0);
      chk("rw.stray", 64'(bus.stray_cnt), 64'd0);
      step();
      rst = 1'b0;
      step();
      chk("rw.cmd_ready", 64'(bus.cmd_ready), 64'd1);
      respond({1'b0, 1'b0, 32'h99999999});
      chk("rw.late_stray", 64'(bus.stray_cnt), 64'd1);
      chk("rw.no_rsp", 64'(bus.rsp_valid), 64'd0);

      // normal read after reset recovery
      send_cmd("rd2", 1'b0, 1'b0, 22'h000044, 32'h0, 4'h0, 63'h44);
      accept_req();
      step();
      respond({1'b0, 1'b0, 32'h0BADCAFE});
      check_rsp("rd2", 32'h0BADCAFE, 1'b0, 1'b0);
      finish_rsp("rd2");
      chk("rd2.stray", 64'(bus.stray_cnt), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
